broadcast_scheduler: RTL and testbench
======================================

# broadcast_scheduler

Shares the single broadcast tree between `REQUESTERS` independent instruction sources. Requests are granted round-robin, and only one instruction is in flight at a time. The scheduler drives the granted message into the tree root for exactly one cycle, then waits for the convergecast response. It returns that response, or a timeout, to the requester that issued the instruction. It sits between the per-client instruction queues and the `broadcast_tree` root.

## Interface
Parameters:
- `MESSAGE_WIDTH`, 16, width of the broadcast instruction.
- `RESPONSE_WIDTH`, 16, width of the convergecast response.
- `REQUESTERS`, 4, number of requesters; legal range 1..16.
- `TIMEOUT`, 64, number of WAIT cycles allowed for a response; must be ≥1.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  REQUESTERS  per-requester instruction valid.
- `req_message`  in  MESSAGE_WIDTH × [0:REQUESTERS-1]  per-requester instruction.
- `req_ready`  out  REQUESTERS  one-hot grant; a transfer happens when valid & ready.
- `bcast_message`  out  MESSAGE_WIDTH  message to the tree root.
- `bcast_valid`  out  1  message strobe to the tree root.
- `resp_valid_in`  in  1  convergecast response strobe.
- `resp_data_in`  in  RESPONSE_WIDTH  convergecast response data.
- `rsp_valid`  out  REQUESTERS  one-hot completion strobe to the issuing requester.
- `rsp_data`  out  RESPONSE_WIDTH  response data returned to the requester.
- `rsp_timeout`  out  1  set together with `rsp_valid` when no response arrived in time.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The state machine has four states: IDLE → ISSUE → WAIT → RESPOND → IDLE.
- **IDLE**
  - `req_ready` is combinational and one-hot on the arbiter winner; it is zero when no request is valid and zero in every other state.
  - Priority order is `last_grant+1`, `last_grant+2`, …, wrapping modulo `REQUESTERS`.
  - On a transfer, the scheduler latches the message and the grant index, updates `last_grant`, and moves to ISSUE.
- **ISSUE**
  - `bcast_valid`=1 and `bcast_message`=latched message for exactly one cycle; then move to WAIT.
  - The wait counter is cleared to 0 on entry to WAIT.
- **WAIT**
  - The counter increments each cycle.
  - If `resp_valid_in`=1, latch `resp_data_in`, clear the timeout flag, and move to RESPOND.
  - Otherwise, if the counter equals `TIMEOUT`-1, set the timeout flag, set the data to 0, and move to RESPOND.
  - If a response arrives in the final WAIT cycle, the response wins and no timeout is reported.
- **RESPOND**
  - `rsp_valid[grant]`=1 for exactly one cycle, with `rsp_data` and `rsp_timeout` held valid alongside it; then return to IDLE.
- `resp_valid_in` is ignored in IDLE, ISSUE and RESPOND; late or spurious responses are discarded.
- `bcast_message` holds its last value when `bcast_valid`=0.
- The counter width is `$clog2(TIMEOUT+1)` and the counter never wraps.
- `REQUESTERS`=1: the grant is always index 0.
- **Reset, including mid-operation:**
  - state returns to IDLE;
  - `last_grant` resets to `REQUESTERS`-1, so requester 0 has first priority;
  - all outputs reset to 0;
  - any in-flight instruction is abandoned with no `rsp_valid`.

## Timing
- A request accepted at cycle T produces `bcast_valid` at T+1.
- WAIT spans T+2 through at most T+1+`TIMEOUT`.
- A response at cycle R produces `rsp_valid` at R+1.
- Timeout case: `rsp_valid` with `rsp_timeout`=1 appears at T+2+`TIMEOUT`.
- Minimum issue period is 4 cycles: the next request can be accepted in the cycle after RESPOND.
- All outputs are registered except `req_ready`, which is combinational from `req_valid` and state.

## Structure
- Package `broadcast_scheduler_pkg` holds:
  - the state enum typedef (IDLE, ISSUE, WAIT, RESPOND);
  - a function computing the counter width.
- Sub-module `rr_arbiter`: combinational round-robin selection.
  - Parameter: `REQUESTERS`.
  - Inputs: request vector and priority pointer.
  - Outputs: one-hot grant and grant index.
- The scheduler itself owns the pointer register.

## Test plan
- **Single request:** requester 2 sends 0x00AB; response 0x1234 arrives 3 cycles after `bcast_valid`.
  - `bcast_valid` is high for one cycle with 0x00AB.
  - `rsp_valid`=4'b0100 with data 0x1234 and `rsp_timeout`=0, one cycle after the response.
- **Fairness:** all four requesters valid continuously, each answered at once.
  - Grant order is 0,1,2,3,0,…
  - Each `req_ready` pulse is one-hot and occurs only in IDLE.
- **Timeout:** `TIMEOUT`=8, no response.
  - `rsp_valid` appears with `rsp_timeout`=1 and data 0 exactly 10 cycles after acceptance.
  - A response arriving afterwards is ignored.
- **Last-cycle race:** response arrives on WAIT counter=`TIMEOUT`-1.
  - `rsp_timeout`=0 and the data is returned.
- **Spurious response:** `resp_valid_in` pulsed in IDLE and in ISSUE.
  - No `rsp_valid` results; the following transaction completes normally.
- **Reset in WAIT:** assert `reset` for one cycle mid-transaction.
  - All outputs are 0, `busy`=0, no `rsp_valid` is produced.
  - The next grant goes to requester 0.

Source files
------------

// File: rtl/broadcast_scheduler_pkg.sv
// Shared types and sizing helpers for the broadcast scheduler and its arbiter.
package broadcast_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // Wide enough to hold TIMEOUT itself, so the wait counter never wraps.
    function automatic int counter_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/broadcast_scheduler_rr_arbiter.sv
// Combinational round-robin selector: the first valid request after the pointer wins.
module rr_arbiter
    import broadcast_scheduler_pkg::*;
#(
    parameter int REQUESTERS = 4,
    localparam int IDX_W = index_width(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]      pointer,
    output logic [REQUESTERS-1:0] grant,
    output logic [IDX_W-1:0]      grant_idx
);

    always_comb begin
        int   cand;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            cand = (int'(pointer) + i) % REQUESTERS;
            if (!found && req[IDX_W'(cand)]) begin
                found                = 1'b1;
                grant[IDX_W'(cand)]  = 1'b1;
                grant_idx            = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/broadcast_scheduler.sv
// Time-shares the broadcast tree root between requesters, one instruction in flight,
// and routes each convergecast response (or a timeout) back to its issuer.
module broadcast_scheduler
    import broadcast_scheduler_pkg::*;
#(
    parameter int MESSAGE_WIDTH  = 16,
    parameter int RESPONSE_WIDTH = 16,
    parameter int REQUESTERS     = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [REQUESTERS-1:0]     req_valid,
    input  logic [MESSAGE_WIDTH-1:0]  req_message [0:REQUESTERS-1],
    output logic [REQUESTERS-1:0]     req_ready,
    output logic [MESSAGE_WIDTH-1:0]  bcast_message,
    output logic                      bcast_valid,
    input  logic                      resp_valid_in,
    input  logic [RESPONSE_WIDTH-1:0] resp_data_in,
    output logic [REQUESTERS-1:0]     rsp_valid,
    output logic [RESPONSE_WIDTH-1:0] rsp_data,
    output logic                      rsp_timeout,
    output logic                      busy
);

    localparam int IDX_W = index_width(REQUESTERS);
    localparam int CNT_W = counter_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(REQUESTERS - 1);

    state_t                 state;
    state_t                 next_state;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       win_idx;
    logic [REQUESTERS-1:0]  win_onehot;
    logic [REQUESTERS-1:0]  grant_onehot;
    logic [CNT_W-1:0]       wait_count;
    logic                   transfer;
    logic                   resp_hit;
    logic                   timed_out;

    rr_arbiter #(
        .REQUESTERS(REQUESTERS)
    ) u_arbiter (
        .req       (req_valid),
        .pointer   (last_grant),
        .grant     (win_onehot),
        .grant_idx (win_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A response in the final WAIT cycle takes precedence over the timeout.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        transfer   = 1'b0;
        resp_hit   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = win_onehot;
                transfer  = |req_valid;
                if (transfer) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = WAIT;
            end
            WAIT: begin
                resp_hit  = resp_valid_in;
                timed_out = !resp_valid_in && (wait_count == CNT_LAST);
                if (resp_hit || timed_out) begin
                    next_state = RESPOND;
                end
            end
            RESPOND: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_onehot = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            grant_onehot[i] = (grant_idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant  <= PTR_INIT;
            bcast_valid <= 1'b0;
            rsp_valid   <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            bcast_valid <= (next_state == ISSUE);
            busy        <= (next_state != IDLE);
            rsp_valid   <= (next_state == RESPOND) ? grant_onehot : '0;
            if (transfer) begin
                last_grant <= win_idx;
            end
            if (resp_hit) begin
                rsp_timeout <= 1'b0;
            end else if (timed_out) begin
                rsp_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bcast_message <= '0;
            rsp_data      <= '0;
        end else begin
            if (transfer) begin
                bcast_message <= req_message[win_idx];
            end
            if (resp_hit) begin
                rsp_data <= resp_data_in;
            end else if (timed_out) begin
                rsp_data <= '0;
            end
        end
    end

    // Saturating guard keeps the counter from wrapping even if WAIT were held.
    always_ff @(posedge clock) begin
        if (transfer) begin
            grant_idx <= win_idx;
        end
        if (state == ISSUE) begin
            wait_count <= '0;
        end else if (state == WAIT && wait_count != CNT_LAST) begin
            wait_count <= wait_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_broadcast_scheduler.sv
// Randomized bench for broadcast_scheduler against a transaction-level reference model.
module tb_broadcast_scheduler;

    localparam int MW = 16;
    localparam int RW = 16;
    localparam int NR = 4;
    localparam int TO = 8;

    logic          clock;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [MW-1:0] req_message [0:NR-1];
    logic [NR-1:0] req_ready;
    logic [MW-1:0] bcast_message;
    logic          bcast_valid;
    logic          resp_valid_in;
    logic [RW-1:0] resp_data_in;
    logic [NR-1:0] rsp_valid;
    logic [RW-1:0] rsp_data;
    logic          rsp_timeout;
    logic          busy;

    int checks;
    int errors;
    int exp_ptr;

    broadcast_scheduler #(
        .MESSAGE_WIDTH (MW),
        .RESPONSE_WIDTH(RW),
        .REQUESTERS    (NR),
        .TIMEOUT       (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_message  (req_message),
        .req_ready    (req_ready),
        .bcast_message(bcast_message),
        .bcast_valid  (bcast_valid),
        .resp_valid_in(resp_valid_in),
        .resp_data_in (resp_data_in),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_timeout  (rsp_timeout),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round-robin rule: first valid requester after the last grant, wrapping.
    function automatic int rr_pick(input int ptr, input logic [NR-1:0] mask);
        for (int i = 1; i <= NR; i++) begin
            if (mask[(ptr + i) % NR]) return (ptr + i) % NR;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bcast_valid"}, bcast_valid, 0);
        check_eq({tag, "_bcast_message"}, bcast_message, 0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        check_eq({tag, "_rsp_data"}, rsp_data, 0);
        check_eq({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_req_ready"}, req_ready, 0);
    endtask

    // Called and returns at the falling edge of an IDLE cycle.
    // d: cycles after bcast_valid at which the response is driven (0 = during ISSUE).
    task automatic run_txn(input logic [NR-1:0] mask, input bit hold, input int d,
                           input bit idle_pulse, input bit issue_pulse, input int reset_at,
                           input bit use_fixed, input logic [MW-1:0] fmsg,
                           input logic [RW-1:0] fdata);
        int            win;
        int            kr;
        bit            answered;
        logic [MW-1:0] msg;
        logic [RW-1:0] data;
        logic [NR-1:0] exp_hot;

        check_eq("idle_busy", busy, 0);
        check_eq("idle_rsp_valid", rsp_valid, 0);
        for (int i = 0; i < NR; i++) begin
            req_message[i] = use_fixed ? fmsg : MW'($urandom);
        end
        req_valid     = mask;
        resp_valid_in = idle_pulse;
        resp_data_in  = RW'($urandom);
        win           = rr_pick(exp_ptr, mask);
        msg           = req_message[win];
        data          = use_fixed ? fdata : RW'($urandom);
        exp_hot       = NR'(1 << win);
        #1;
        check_eq("req_ready_grant", req_ready, exp_hot);
        exp_ptr = win;

        @(negedge clock);
        check_eq("issue_bcast_valid", bcast_valid, 1);
        check_eq("issue_bcast_message", bcast_message, msg);
        check_eq("issue_busy", busy, 1);
        check_eq("issue_rsp_valid", rsp_valid, 0);
        check_eq("issue_req_ready", req_ready, 0);
        if (!hold) req_valid = '0;
        resp_valid_in = issue_pulse || (d == 0);
        resp_data_in  = issue_pulse ? ~data : data;

        answered = (d >= 1) && (d <= TO);
        kr       = answered ? d + 1 : TO + 1;
        for (int k = 1; k <= kr; k++) begin
            @(negedge clock);
            if (reset_at == k) begin
                reset         = 1'b1;
                resp_valid_in = 1'b0;
                req_valid     = '0;
                @(negedge clock);
                check_all_zero("reset");
                reset   = 1'b0;
                exp_ptr = NR - 1;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clock);
                    check_eq("post_reset_rsp_valid", rsp_valid, 0);
                    check_eq("post_reset_busy", busy, 0);
                end
                return;
            end
            check_eq("wait_bcast_valid", bcast_valid, 0);
            check_eq("hold_bcast_message", bcast_message, msg);
            check_eq("wait_req_ready", req_ready, 0);
            check_eq("wait_busy", busy, 1);
            if (k < kr) begin
                check_eq("early_rsp_valid", rsp_valid, 0);
            end else begin
                check_eq("rsp_valid", rsp_valid, exp_hot);
                check_eq("rsp_data", rsp_data, answered ? data : '0);
                check_eq("rsp_timeout", rsp_timeout, answered ? 0 : 1);
            end
            resp_valid_in = (k == d);
            resp_data_in  = data;
        end
        @(negedge clock);
        resp_valid_in = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_ptr       = NR - 1;
        reset         = 1'b1;
        req_valid     = '0;
        resp_valid_in = 1'b0;
        resp_data_in  = '0;
        for (int i = 0; i < NR; i++) req_message[i] = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("init");
        reset = 1'b0;
        @(negedge clock);

        // Single request from requester 2, answered 3 cycles after the broadcast.
        run_txn(4'b0100, 0, 3, 0, 0, 0, 1, 16'h00AB, 16'h1234);

        // Fairness: everyone valid continuously, immediate answers.
        for (int n = 0; n < 8; n++) run_txn(4'hF, 1, 1, 0, 0, 0, 0, '0, '0);
        req_valid = '0;

        // Timeout with a late response landing in RESPOND, then one in IDLE.
        run_txn(4'b0011, 0, TO + 1, 0, 0, 0, 0, '0, '0);
        run_txn(4'b1000, 0, 2, 1, 0, 0, 0, '0, '0);

        // Response on the last WAIT cycle wins over the timeout.
        run_txn(4'b0110, 0, TO, 0, 0, 0, 0, '0, '0);

        // Spurious responses in IDLE and ISSUE, then a normal completion.
        run_txn(4'b0001, 0, 2, 1, 1, 0, 0, '0, '0);
        run_txn(4'b0100, 0, 0, 0, 0, 0, 0, '0, '0);

        // Reset while waiting; the next grant must go to requester 0.
        run_txn(4'b0100, 0, 6, 0, 0, 3, 0, '0, '0);
        run_txn(4'hF, 0, 1, 0, 0, 0, 0, '0, '0);

        for (int n = 0; n < 40; n++) begin
            run_txn(NR'($urandom_range(1, 15)), bit'($urandom_range(0, 1)),
                    int'($urandom_range(0, TO + 1)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), 0, 0, '0, '0);
        end
        req_valid = '0;
        repeat (2) @(negedge clock);
        check_eq("final_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
